// File: rtl/unidade_controle_multiciclo_if.sv
// Control-unit bundle: opcode/input-valid toward the FSM, datapath controls back.
interface unidade_controle_multiciclo_if #(
    parameter int OPCODE_W = 6,
    parameter int SINAL_W  = 6
);
    logic [OPCODE_W-1:0] OpCode;
    logic                Entrada_Valida;
    logic [1:0]          Reg_Dst;
    logic                ALU_Op;
    logic                Mem_Read;
    logic                Mem_Write;
    logic                Mem_To_Reg;
    logic                Reg_Write;
    logic                ALU_Src;
    logic                PC_Src;
    logic                Print;
    logic                Jump_Register;
    logic [1:0]          Entrada;
    logic                Esperar_Entrada;
    logic [SINAL_W-1:0]  Sinal;
    logic                PC_Write;
    logic                PC_Write_Cond;
    logic                IR_Write;
    logic [2:0]          Estado;
    logic                Erro_Opcode;

    modport slave (
        input  OpCode, Entrada_Valida,
        output Reg_Dst, ALU_Op, Mem_Read, Mem_Write, Mem_To_Reg, Reg_Write,
               ALU_Src, PC_Src, Print, Jump_Register, Entrada, Esperar_Entrada,
               Sinal, PC_Write, PC_Write_Cond, IR_Write, Estado, Erro_Opcode
    );

    modport master (
        output OpCode, Entrada_Valida,
        input  Reg_Dst, ALU_Op, Mem_Read, Mem_Write, Mem_To_Reg, Reg_Write,
               ALU_Src, PC_Src, Print, Jump_Register, Entrada, Esperar_Entrada,
               Sinal, PC_Write, PC_Write_Cond, IR_Write, Estado, Erro_Opcode
    );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle Moore control unit: fetch/decode/execute/memory/writeback/wait.
module unidade_controle_multiciclo #(
    parameter int OPCODE_W = 6,
    parameter int SINAL_W  = 6,
    parameter int MEM_LAT  = 1
) (
    input  logic                          Clock,
    input  logic                          Reset,
    unidade_controle_multiciclo_if.slave  bus
);
    typedef enum logic [2:0] {
        BUSCA      = 3'd0,
        DECODIFICA = 3'd1,
        EXECUTA    = 3'd2,
        MEMORIA    = 3'd3,
        ESCRITA    = 3'd4,
        ESPERA     = 3'd5
    } estado_t;

    typedef logic [OPCODE_W-1:0] op_t;
    localparam op_t OP_R    = op_t'(6'h00);
    localparam op_t OP_ADDI = op_t'(6'h01);
    localparam op_t OP_SUBI = op_t'(6'h02);
    localparam op_t OP_LW   = op_t'(6'h03);
    localparam op_t OP_SW   = op_t'(6'h04);
    localparam op_t OP_BEQ  = op_t'(6'h05);
    localparam op_t OP_BNE  = op_t'(6'h06);
    localparam op_t OP_J    = op_t'(6'h07);
    localparam op_t OP_JI   = op_t'(6'h08);
    localparam op_t OP_JR   = op_t'(6'h09);
    localparam op_t OP_OUT  = op_t'(6'h0A);
    localparam op_t OP_IN   = op_t'(6'h0B);
    localparam op_t OP_JAL  = op_t'(6'h0C);
    localparam op_t OP_WAIT = op_t'(6'h0D);
    localparam op_t OP_LI   = op_t'(6'h3F);
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    estado_t      state_q, state_d;
    op_t          op_q, op_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         erro_q, erro_d;

    logic [1:0]         reg_dst, entrada;
    logic [SINAL_W-1:0] sinal;
    logic alu_op, alu_src, mem_read, mem_write, mem_to_reg, reg_write;
    logic pc_src, pc_write, pc_write_cond, ir_write, print, jump_reg, esperar;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= BUSCA;
            op_q    <= '0;
            cnt_q   <= '0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            erro_q  <= erro_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        erro_d        = erro_q;
        reg_dst       = 2'b00;
        entrada       = 2'b00;
        sinal         = '0;
        alu_op        = 1'b0;
        alu_src       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        pc_src        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        print         = 1'b0;
        jump_reg      = 1'b0;
        esperar       = 1'b0;

        // ALU/destination selects stay stable from EXECUTA through writeback
        if (state_q == EXECUTA || state_q == MEMORIA || state_q == ESCRITA) begin
            case (op_q)
                OP_R:         begin alu_op = 1'b1; reg_dst = 2'b01; end
                OP_ADDI:      alu_src = 1'b1;
                OP_SUBI:      begin alu_src = 1'b1; sinal = SINAL_W'(6'h01); end
                OP_LW, OP_SW: alu_src = 1'b1;
                OP_BEQ:       sinal = SINAL_W'(6'h21);
                OP_BNE:       sinal = SINAL_W'(6'h23);
                OP_JI:        sinal = SINAL_W'(6'h01);
                OP_JAL:       begin sinal = SINAL_W'(6'h20); reg_dst = 2'b10; entrada = 2'b10; end
                OP_LI:        reg_dst = 2'b01;
                OP_IN:        entrada = 2'b01;
                default:      ;
            endcase
        end

        case (state_q)
            BUSCA: begin
                // Reset holds the fetch strobes low even though the state is BUSCA
                ir_write = ~Reset;
                pc_write = ~Reset;
                state_d  = DECODIFICA;
            end
            DECODIFICA: begin
                op_d = bus.OpCode;
                if (bus.OpCode == OP_WAIT)
                    state_d = ESPERA;
                else if (bus.OpCode < OP_WAIT || bus.OpCode == OP_LI)
                    state_d = EXECUTA;
                else begin
                    state_d = BUSCA;
                    erro_d  = 1'b1;
                end
            end
            EXECUTA: begin
                state_d = BUSCA;
                case (op_q)
                    OP_LW, OP_SW: begin state_d = MEMORIA; cnt_d = CNT_LOAD; end
                    OP_R, OP_ADDI, OP_SUBI, OP_IN, OP_LI: state_d = ESCRITA;
                    OP_BEQ, OP_BNE: begin pc_src = 1'b1; pc_write_cond = 1'b1; end
                    OP_J, OP_JI:    begin pc_src = 1'b1; pc_write = 1'b1; end
                    OP_JR:          begin jump_reg = 1'b1; pc_write = 1'b1; end
                    OP_JAL:         begin pc_src = 1'b1; pc_write = 1'b1; reg_write = 1'b1; end
                    OP_OUT:         print = 1'b1;
                    default: ;
                endcase
            end
            MEMORIA: begin
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q != OP_LW);
                if (cnt_q == 4'd0)
                    state_d = (op_q == OP_LW) ? ESCRITA : BUSCA;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            ESCRITA: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OP_LW);
                state_d    = BUSCA;
            end
            ESPERA: begin
                esperar = 1'b1;
                if (bus.Entrada_Valida)
                    state_d = BUSCA;
            end
            default: state_d = BUSCA;
        endcase
    end

    assign bus.Reg_Dst         = reg_dst;
    assign bus.ALU_Op          = alu_op;
    assign bus.Mem_Read        = mem_read;
    assign bus.Mem_Write       = mem_write;
    assign bus.Mem_To_Reg      = mem_to_reg;
    assign bus.Reg_Write       = reg_write;
    assign bus.ALU_Src         = alu_src;
    assign bus.PC_Src          = pc_src;
    assign bus.Print           = print;
    assign bus.Jump_Register   = jump_reg;
    assign bus.Entrada         = entrada;
    assign bus.Esperar_Entrada = esperar;
    assign bus.Sinal           = sinal;
    assign bus.PC_Write        = pc_write;
    assign bus.PC_Write_Cond   = pc_write_cond;
    assign bus.IR_Write        = ir_write;
    assign bus.Estado          = state_q;
    assign bus.Erro_Opcode     = erro_q;
endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench: expected per-cycle outputs queued by stimulus, checked by a monitor.
module tb_unidade_controle_multiciclo;
    localparam int MEM_LAT = 3;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    unidade_controle_multiciclo_if #(.OPCODE_W(6), .SINAL_W(6)) bus ();

    unidade_controle_multiciclo #(.OPCODE_W(6), .SINAL_W(6), .MEM_LAT(MEM_LAT)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [2:0] estado;
        logic [1:0] reg_dst;
        logic [1:0] entrada;
        logic [5:0] sinal;
        logic alu_op, alu_src, mem_read, mem_write, mem_to_reg, reg_write;
        logic pc_src, pc_write, pc_write_cond, ir_write, print, jump_reg;
        logic esperar, erro;
    } obs_t;

    obs_t  exq[$];
    string nmq[$];
    int    checks = 0;
    int    passed = 0;
    logic  err_exp = 1'b0;
    event  smp;
    obs_t  e;

    function automatic obs_t sample();
        obs_t a;
        a.estado        = bus.Estado;
        a.reg_dst       = bus.Reg_Dst;
        a.entrada       = bus.Entrada;
        a.sinal         = bus.Sinal;
        a.alu_op        = bus.ALU_Op;
        a.alu_src       = bus.ALU_Src;
        a.mem_read      = bus.Mem_Read;
        a.mem_write     = bus.Mem_Write;
        a.mem_to_reg    = bus.Mem_To_Reg;
        a.reg_write     = bus.Reg_Write;
        a.pc_src        = bus.PC_Src;
        a.pc_write      = bus.PC_Write;
        a.pc_write_cond = bus.PC_Write_Cond;
        a.ir_write      = bus.IR_Write;
        a.print         = bus.Print;
        a.jump_reg      = bus.Jump_Register;
        a.esperar       = bus.Esperar_Entrada;
        a.erro          = bus.Erro_Opcode;
        return a;
    endfunction

    function automatic obs_t blank(input logic [2:0] st);
        obs_t b = '0;
        b.estado = st;
        b.erro   = err_exp;
        if (st == 3'd0 && !Reset) begin
            b.ir_write = 1'b1;
            b.pc_write = 1'b1;
        end
        return b;
    endfunction

    // Monitor: checks one queued expectation per falling edge (or on demand).
    initial begin
        obs_t x, a;
        string n;
        forever begin
            @(negedge Clock or smp);
            if (exq.size() > 0) begin
                x = exq.pop_front();
                n = nmq.pop_front();
                a = sample();
                checks++;
                if (a === x) passed++;
                else $display("FAIL %s: got %h expected %h", n, a, x);
            end
        end
    end

    task automatic step(input obs_t v, input string n);
        exq.push_back(v);
        nmq.push_back(n);
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch_decode(input logic [5:0] op, input string n);
        bus.OpCode = op;
        step(blank(3'd0), {n, " busca"});
        step(blank(3'd1), {n, " decod"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.OpCode         = 6'h00;
        bus.Entrada_Valida = 1'b0;
        @(posedge Clock); #1;
        step(blank(3'd0), "reset0");
        step(blank(3'd0), "reset1");
        Reset = 1'b0;

        // addi; opcode changes after decode must not matter
        fetch_decode(6'h01, "addi");
        bus.OpCode = 6'h2E;
        e = blank(3'd2); e.alu_src = 1; step(e, "addi exec");
        e = blank(3'd4); e.alu_src = 1; e.reg_write = 1; step(e, "addi wb");

        // lw with MEM_LAT=3
        fetch_decode(6'h03, "lw");
        e = blank(3'd2); e.alu_src = 1; step(e, "lw exec");
        for (int i = 0; i < MEM_LAT; i++) begin
            e = blank(3'd3); e.alu_src = 1; e.mem_read = 1; step(e, "lw mem");
        end
        e = blank(3'd4); e.alu_src = 1; e.mem_to_reg = 1; e.reg_write = 1; step(e, "lw wb");

        // sw
        fetch_decode(6'h04, "sw");
        e = blank(3'd2); e.alu_src = 1; step(e, "sw exec");
        for (int i = 0; i < MEM_LAT; i++) begin
            e = blank(3'd3); e.alu_src = 1; e.mem_write = 1; step(e, "sw mem");
        end

        fetch_decode(6'h00, "r");
        e = blank(3'd2); e.alu_op = 1; e.reg_dst = 2'b01; step(e, "r exec");
        e = blank(3'd4); e.alu_op = 1; e.reg_dst = 2'b01; e.reg_write = 1; step(e, "r wb");

        fetch_decode(6'h02, "subi");
        e = blank(3'd2); e.alu_src = 1; e.sinal = 6'h01; step(e, "subi exec");
        e = blank(3'd4); e.alu_src = 1; e.sinal = 6'h01; e.reg_write = 1; step(e, "subi wb");

        fetch_decode(6'h05, "beq");
        e = blank(3'd2); e.sinal = 6'h21; e.pc_src = 1; e.pc_write_cond = 1; step(e, "beq exec");
        fetch_decode(6'h06, "bne");
        e = blank(3'd2); e.sinal = 6'h23; e.pc_src = 1; e.pc_write_cond = 1; step(e, "bne exec");
        fetch_decode(6'h07, "j");
        e = blank(3'd2); e.pc_src = 1; e.pc_write = 1; step(e, "j exec");
        fetch_decode(6'h08, "ji");
        e = blank(3'd2); e.sinal = 6'h01; e.pc_src = 1; e.pc_write = 1; step(e, "ji exec");
        fetch_decode(6'h09, "jr");
        e = blank(3'd2); e.jump_reg = 1; e.pc_write = 1; step(e, "jr exec");
        fetch_decode(6'h0A, "out");
        e = blank(3'd2); e.print = 1; step(e, "out exec");

        fetch_decode(6'h0B, "in");
        e = blank(3'd2); e.entrada = 2'b01; step(e, "in exec");
        e = blank(3'd4); e.entrada = 2'b01; e.reg_write = 1; step(e, "in wb");

        fetch_decode(6'h0C, "jal");
        e = blank(3'd2); e.sinal = 6'h20; e.reg_dst = 2'b10; e.entrada = 2'b10;
        e.pc_src = 1; e.pc_write = 1; e.reg_write = 1; step(e, "jal exec");

        fetch_decode(6'h3F, "li");
        e = blank(3'd2); e.reg_dst = 2'b01; step(e, "li exec");
        e = blank(3'd4); e.reg_dst = 2'b01; e.reg_write = 1; step(e, "li wb");

        // wait: 5 cycles without valid, then valid
        fetch_decode(6'h0D, "wait");
        for (int i = 0; i < 6; i++) begin
            bus.Entrada_Valida = (i == 5);
            e = blank(3'd5); e.esperar = 1; step(e, "wait espera");
        end
        bus.Entrada_Valida = 1'b0;

        // illegal opcode: error sticks across the next instruction
        fetch_decode(6'h2A, "illegal");
        err_exp = 1'b1;
        fetch_decode(6'h00, "r after err");
        e = blank(3'd2); e.alu_op = 1; e.reg_dst = 2'b01; step(e, "r after err exec");
        e = blank(3'd4); e.alu_op = 1; e.reg_dst = 2'b01; e.reg_write = 1; step(e, "r after err wb");

        // sw aborted by reset during the second memory cycle
        fetch_decode(6'h04, "sw abort");
        e = blank(3'd2); e.alu_src = 1; step(e, "sw abort exec");
        e = blank(3'd3); e.alu_src = 1; e.mem_write = 1; step(e, "sw abort mem1");
        e = blank(3'd3); e.alu_src = 1; e.mem_write = 1;
        exq.push_back(e); nmq.push_back("sw abort mem2");
        @(negedge Clock); #1;
        Reset = 1'b1;
        err_exp = 1'b0;
        #1;
        exq.push_back(blank(3'd0)); nmq.push_back("async reset");
        ->smp;
        @(posedge Clock); #1;
        step(blank(3'd0), "held reset");
        Reset = 1'b0;
        bus.OpCode = 6'h07;
        fetch_decode(6'h07, "j after reset");
        e = blank(3'd2); e.pc_src = 1; e.pc_write = 1; step(e, "j after reset exec");
        step(blank(3'd0), "busca final");

        @(negedge Clock); #1;
        checks++;
        if (exq.size() == 0) passed++;
        else $display("FAIL queue drain: got %0d expected 0", exq.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
